mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 16K x 32 word memory between two requesters:
//  instruction fetch (IF) and load/store (LS). One access per cycle,
//  round-robin on contention, read data routed back to its owner.
//  Sits between the cpu core and the memory instance.
// PARAMETERS
//  ADDR_W    14  word address width (matches memory depth)
//  DATA_W    32  data word width
//  RD_LAT    1   memory read latency in cycles (>=1); i_mem_rdata valid RD_LAT edges after issue
// PORTS
//  i_clk        in   1       single clock, all logic posedge
//  i_rst_n      in   1       reset: asynchronous, active-low
//  i_if_req     in   1       IF read request; held with i_if_addr stable until granted
//  i_if_addr    in   ADDR_W  IF word address
//  o_if_gnt     out  1       IF request accepted this cycle
//  o_if_rvalid  out  1       IF read data valid
//  o_if_rdata   out  DATA_W  IF read data
//  i_ls_req     in   1       LS request; held with addr/we/wdata/wmask stable until granted
//  i_ls_we      in   1       1 = write, 0 = read
//  i_ls_addr    in   ADDR_W  LS word address
//  i_ls_wdata   in   DATA_W  LS write data
//  i_ls_wmask   in   DATA_W/8  LS byte enables (write only)
//  o_ls_gnt     out  1       LS request accepted this cycle
//  o_ls_rvalid  out  1       LS read data valid (never for writes)
//  o_ls_rdata   out  DATA_W  LS read data
//  o_mem_read   out  1       memory read strobe
//  o_mem_write  out  1       memory write strobe
//  o_mem_addr   out  ADDR_W  memory address
//  o_mem_wdata  out  DATA_W  memory write data
//  o_mem_wmask  out  DATA_W/8  memory byte enables
//  i_mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//  - Grant is combinational, same cycle as req; memory command is driven
//    combinationally from the winner and sampled by memory at the next edge.
//  - Exactly one of o_if_gnt/o_ls_gnt high when any req high; never both.
//  - Single requester: always granted, no bubble.
//  - Both requesting: winner = requester NOT granted last (last_owner reg).
//    last_owner updates only on a grant. Reset value last_owner = LS, so
//    IF wins the first tie after reset.
//  - Idle (no req): o_mem_read=o_mem_write=0, o_mem_addr/wdata/wmask = 0.
//  - Read grant: push {valid=1, owner} into RD_LAT-deep tag shift register;
//    write or idle pushes valid=0. Tag at tail drives o_<owner>_rvalid;
//    o_if_rdata = o_ls_rdata = i_mem_rdata (unqualified, gated by rvalid).
//  - Latency: grant cycle N -> rvalid high in cycle N+RD_LAT, one cycle.
//  - Back-to-back reads fully pipelined: 1 response/cycle, issue order kept.
//  - No backpressure on responses: requesters must accept rvalid.
//  - Reset (async assert, any time): all gnt/rvalid/mem strobes 0
//    immediately; tag pipe cleared, in-flight reads dropped; last_owner=LS.
//    Deassertion is synchronised by the top level; first grant possible
//    in the first cycle after release.
//  - Width: wmask width DATA_W/8; DATA_W must be multiple of 8.
// STRUCTURE
//  - mem_arb_pkg: ADDR_W/DATA_W defaults, owner encoding
//    OWNER_IF=1'b0, OWNER_LS=1'b1.
//  - Sub-module mem_arb_rsp_pipe: RD_LAT-deep {valid,owner} shift register
//    with async active-low clear; arbiter top holds the grant logic, the
//    last_owner reg and the command mux.
// TESTING
//  - IF only, addr 0..3 back-to-back -> o_if_gnt each cycle, o_mem_read=1,
//    o_if_rvalid cycles 1..4 with mem[0..3]; o_ls_rvalid never high.
//  - Both req from reset, IF@0x10, LS read@0x20 held -> grants IF,LS,IF,LS...
//    alternate; rvalid owners follow the same order RD_LAT later.
//  - LS write 0xDEADBEEF wmask 4'b0011 @0x5, then LS read @0x5 ->
//    no rvalid for write, read returns 0x....BEEF (upper bytes unchanged).
//  - RD_LAT=3: IF read granted cycle N -> o_if_rvalid only in N+3.
//  - Assert i_rst_n=0 with 1 read in flight -> rvalid never fires; after
//    release both req -> IF granted first.
//  - No req for 5 cycles -> all strobes 0, addr 0, no gnt, no rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: owner encoding and
// the response tag carried through the read-latency pipe.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rsp_tag_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: both requester ports plus the memory port.
// slave = arbiter view, master = core/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic                i_ls_req;
  logic                i_ls_we;
  logic [ADDR_W-1:0]   i_ls_addr;
  logic [DATA_W-1:0]   i_ls_wdata;
  logic [DATA_W/8-1:0] i_ls_wmask;
  logic                o_ls_gnt;
  logic                o_ls_rvalid;
  logic [DATA_W-1:0]   o_ls_rdata;

  logic                o_mem_read;
  logic                o_mem_write;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [DATA_W-1:0]   o_mem_wdata;
  logic [DATA_W/8-1:0] o_mem_wmask;
  logic [DATA_W-1:0]   i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_wmask,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_wmask,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_arb_rsp_pipe.sv
// RD_LAT-deep {valid,owner} delay line; the tail lines up with the memory's
// read data so it says who (if anyone) owns the current i_mem_rdata.
module mem_arb_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  rsp_tag_t push_i,
  output rsp_tag_t tail_o
);
  rsp_tag_t tag_q [RD_LAT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail_o = tag_q[RD_LAT-1];
endmodule

// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter in front of a single-port memory. Grant and
// memory command are combinational; read data is routed back by owner tag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int MASK_W = DATA_W / 8;

  owner_e   last_owner_q, last_owner_d;
  logic     if_gnt, ls_gnt;
  logic     mem_rd, mem_wr;
  rsp_tag_t push_tag, tail_tag;

  // Grants are forced low while reset is asserted so nothing leaks out
  // between async assert and the next edge.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (i_rst_n) begin
      if (bus.i_if_req && bus.i_ls_req) begin
        if (last_owner_q == OWNER_LS) if_gnt = 1'b1;
        else                          ls_gnt = 1'b1;
      end else begin
        if_gnt = bus.i_if_req;
        ls_gnt = bus.i_ls_req;
      end
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (if_gnt)      last_owner_d = OWNER_IF;
    else if (ls_gnt) last_owner_d = OWNER_LS;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_owner_q <= OWNER_LS;
    else          last_owner_q <= last_owner_d;
  end

  assign mem_rd = if_gnt | (ls_gnt & ~bus.i_ls_we);
  assign mem_wr = ls_gnt & bus.i_ls_we;

  // Unused command fields are zeroed rather than left floating on the bus.
  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_wmask = '0;
    if (if_gnt) begin
      bus.o_mem_addr = bus.i_if_addr;
    end else if (ls_gnt) begin
      bus.o_mem_addr = bus.i_ls_addr;
      if (bus.i_ls_we) begin
        bus.o_mem_wdata = bus.i_ls_wdata;
        bus.o_mem_wmask = bus.i_ls_wmask;
      end
    end
  end

  assign bus.o_mem_read  = mem_rd;
  assign bus.o_mem_write = mem_wr;
  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_ls_gnt    = ls_gnt;

  assign push_tag.valid = mem_rd;
  assign push_tag.owner = ls_gnt ? OWNER_LS : OWNER_IF;

  mem_arb_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push_i  (push_tag),
    .tail_o  (tail_tag)
  );

  assign bus.o_if_rvalid = tail_tag.valid && (tail_tag.owner == OWNER_IF);
  assign bus.o_ls_rvalid = tail_tag.valid && (tail_tag.owner == OWNER_LS);
  assign bus.o_if_rdata  = bus.i_mem_rdata;
  assign bus.o_ls_rdata  = bus.i_mem_rdata;

  logic [MASK_W-1:0] unused_mask_w;
  assign unused_mask_w = '0;
endmodule
